// File: rtl/vga_pmod_tx.sv
// vga_pmod_tx - 640x480@60 VGA timing and test-pattern source, packed into the
// TinyVGA PMOD byte {R1,G1,B1,vsync,R0,G0,B0,hsync}.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   en           pixel advance enable; low freezes every register
//   pattern_sel  0 black, 1 colour bars, 2 scrolling checker, 3 gradient
//   pmod         registered packed VGA byte
//   hpos, vpos   current horizontal / vertical counters
//   video_active registered, high when pmod carries a visible pixel
//   frame_start  registered pulse aligned with pixel (0,0) on pmod
//   frame_count  completed-frame counter (wraps at 256)
//
// pmod/video_active/frame_start are decoded from the counter values before
// the edge, so they trail hpos/vpos by one cycle.
module vga_pmod_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pmod,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       video_active,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);

  // syncs deasserted, colour black
  localparam logic [7:0] IDLE = {3'b000, ~SYNC_ACTIVE, 3'b000, ~SYNC_ACTIVE};

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  logic [1:0] pat;
  logic       h_last, v_last, active, hs_lvl, vs_lvl, chk;
  logic [9:0] bar_full;
  logic [2:0] bar;
  logic [5:0] scroll;
  rgb_t       col;
  logic [7:0] pmod_nxt;
  logic       unused_bits;

  always_comb begin
    h_last = (hpos == H_LAST);
    v_last = (vpos == V_LAST);
    active = (hpos < H_ACT) && (vpos < V_ACT);
    hs_lvl = (hpos >= HS_BEG && hpos < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_lvl = (vpos >= VS_BEG && vpos < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // Only bar indices 0..7 occur while active; upper quotient bits are don't-care.
    bar_full = hpos / BAR_W;
    bar      = bar_full[2:0];

    // Bit 5 of a sum depends only on the low 6 bits of the addends, so the
    // 10-bit modulo add reduces to a 6-bit add here.
    scroll = hpos[5:0] + frame_count[5:0];
    chk    = scroll[5] ^ vpos[5];

    col = '0;
    if (active) begin
      unique case (pat)
        2'd0: col = '0;
        2'd1: begin
          unique case (bar)
            3'd0: col = '{r: 2'd3, g: 2'd3, b: 2'd3};  // white
            3'd1: col = '{r: 2'd3, g: 2'd3, b: 2'd0};  // yellow
            3'd2: col = '{r: 2'd0, g: 2'd3, b: 2'd3};  // cyan
            3'd3: col = '{r: 2'd0, g: 2'd3, b: 2'd0};  // green
            3'd4: col = '{r: 2'd3, g: 2'd0, b: 2'd3};  // magenta
            3'd5: col = '{r: 2'd3, g: 2'd0, b: 2'd0};  // red
            3'd6: col = '{r: 2'd0, g: 2'd0, b: 2'd3};  // blue
            default: col = '0;                          // black
          endcase
        end
        2'd2: col = chk ? 6'b11_11_11 : 6'b00_00_00;
        default: col = '{r: hpos[7:6], g: vpos[7:6], b: frame_count[7:6]};
      endcase
    end

    pmod_nxt = {col.r[1], col.g[1], col.b[1], vs_lvl,
                col.r[0], col.g[0], col.b[0], hs_lvl};
  end

  assign unused_bits = ^{bar_full[9:3], scroll[4:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos         <= '0;
      vpos         <= '0;
      frame_count  <= '0;
      pat          <= pattern_sel;
      pmod         <= IDLE;
      video_active <= 1'b0;
      frame_start  <= 1'b0;
    end else if (en) begin
      if (h_last) begin
        hpos <= '0;
        if (v_last) begin
          vpos        <= '0;
          frame_count <= frame_count + 8'd1;
          pat         <= pattern_sel;   // pattern only changes between frames
        end else begin
          vpos <= vpos + 10'd1;
        end
      end else begin
        hpos <= hpos + 10'd1;
      end
      pmod         <= pmod_nxt;
      video_active <= active;
      frame_start  <= (hpos == 10'd0) && (vpos == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_pmod_tx.sv
// Scoreboard bench for vga_pmod_tx. Horizontal timing is the real 800-clock
// line; vertical timing is shortened (50 lines) so several frames fit in a
// short run. Expected outputs come from a pixel-index model of the raster.
module tb_vga_pmod_tx;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 40,  VF = 4,  VS = 2,  VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit SA = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] pmod;
  logic [9:0] hpos, vpos;
  logic       video_active, frame_start;
  logic [7:0] frame_count;

  vga_pmod_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .pmod(pmod), .hpos(hpos), .vpos(vpos), .video_active(video_active),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [7:0] pmod;
    logic [9:0] h;
    logic [9:0] v;
    logic       va;
    logic       fs;
    logic [7:0] fc;
    bit         en;
    bit         rst;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference raster state: position as a linear pixel index within the frame
  int   mh = 0, mv = 0, mfc = 0, mpat = 0;
  exp_t last;
  int   burst = 0;

  int BAR_R[8] = '{3, 3, 0, 0, 3, 3, 0, 0};
  int BAR_G[8] = '{3, 3, 3, 3, 0, 0, 0, 0};
  int BAR_B[8] = '{3, 0, 3, 0, 3, 0, 3, 0};

  function automatic logic [7:0] pix(int h, int v, int fc, int pat);
    int r, g, b, c, hsb, vsb;
    r = 0; g = 0; b = 0;
    if (h < HA && v < VA) begin
      case (pat)
        1: begin r = BAR_R[h / (HA / 8)]; g = BAR_G[h / (HA / 8)]; b = BAR_B[h / (HA / 8)]; end
        2: begin c = (((h + fc) % 1024) / 32 + v / 32) % 2; r = 3 * c; g = 3 * c; b = 3 * c; end
        3: begin r = (h / 64) % 4; g = (v / 64) % 4; b = fc / 64; end
        default: ;
      endcase
    end
    hsb = (h >= HA + HF && h < HA + HF + HS) ? int'(SA) : 1 - int'(SA);
    vsb = (v >= VA + VF && v < VA + VF + VS) ? int'(SA) : 1 - int'(SA);
    return 8'((r / 2) * 128 + (g / 2) * 64 + (b / 2) * 32 + vsb * 16 +
              (r % 2) * 8 + (g % 2) * 4 + (b % 2) * 2 + hsb);
  endfunction

  function automatic bit rnd_en();
    if (burst > 0) begin burst--; return 1'b0; end
    if ($urandom_range(0, 99) == 0) begin burst = int'($urandom_range(0, 7)); return 1'b0; end
    return 1'b1;
  endfunction

  // drive one clock of stimulus and queue the outputs expected after that edge
  task automatic step(input bit r, input bit e, input logic [1:0] s);
    exp_t x;
    int   t;
    @(negedge clk);
    rst_n = r; en = e; pattern_sel = s;
    x = last;
    x.en = e; x.rst = r;
    if (!r) begin
      mh = 0; mv = 0; mfc = 0; mpat = int'(s);
      x.pmod = {3'b000, ~SA, 3'b000, ~SA};
      x.va = 1'b0; x.fs = 1'b0;
    end else if (e) begin
      x.pmod = pix(mh, mv, mfc, mpat);
      x.va   = (mh < HA) && (mv < VA);
      x.fs   = (mh == 0) && (mv == 0);
      t = mv * HT + mh + 1;
      if (t == HT * VT) begin
        t = 0; mfc = (mfc + 1) % 256; mpat = int'(s);
      end
      mh = t % HT; mv = t / HT;
    end
    x.h = 10'(mh); x.v = 10'(mv); x.fc = 8'(mfc);
    last = x;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // monitor: pop one expectation per edge, plus interval checks measured
  // purely from the observed outputs in enabled cycles
  initial begin
    exp_t x;
    int hrun = 0, vrun = 0, fcnt = 0;
    bit seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        n_chk++;
        if ({pmod, hpos, vpos, video_active, frame_start, frame_count} !==
            {x.pmod, x.h, x.v, x.va, x.fs, x.fc}) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got pmod=%h h=%0d v=%0d va=%b fs=%b fc=%0d expected pmod=%h h=%0d v=%0d va=%b fs=%b fc=%0d",
                   $time, pmod, hpos, vpos, video_active, frame_start, frame_count,
                   x.pmod, x.h, x.v, x.va, x.fs, x.fc);
        end
        if (!x.rst) begin
          hrun = 0; vrun = 0; fcnt = 0; seen = 0;
        end else if (x.en) begin
          if (pmod[0] == SA) hrun++;
          else if (hrun > 0) begin chk("hsync_width", hrun, HS); hrun = 0; end
          if (pmod[4] == SA) vrun++;
          else if (vrun > 0) begin chk("vsync_width", vrun, VS * HT); vrun = 0; end
          fcnt++;
          if (frame_start) begin
            if (seen) chk("frame_period", fcnt, HT * VT);
            seen = 1; fcnt = 0;
          end
        end
        if (n_fail >= 50) begin
          $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin
    bit sel3 = 0, froze = 0;
    int guard;
    last = '{pmod: 8'h00, h: 10'd0, v: 10'd0, va: 1'b0, fs: 1'b0, fc: 8'd0, en: 1'b0, rst: 1'b0};

    // reset with bars selected, first enabled pixel is white bar 0
    repeat (3) step(0, 1, 2'd1);
    step(1, 1, 2'd1);
    repeat (2000) step(1, rnd_en(), 2'($urandom));

    // bars frame; switch to gradient at (100,10), 50-cycle freeze at (400,5),
    // run through the wrap and reset at (300,20) of the next frame
    repeat (2) step(0, 1, 2'd1);
    guard = 0;
    while (!(mfc == 1 && mv == 20 && mh == 300) && guard < 90000) begin
      if (mh == 100 && mv == 10) sel3 = 1;
      if (!froze && mh == 400 && mv == 5) begin
        froze = 1;
        repeat (50) step(1, 0, 2'd1);
      end
      step(1, rnd_en(), sel3 ? 2'd3 : 2'($urandom));
      guard++;
    end
    chk("reached_reset_point", guard < 90000 ? 1 : 0, 1);

    // reset mid-frame into the checker pattern
    step(0, 1, 2'd2);
    repeat (1800) step(1, rnd_en(), 2'($urandom));

    // pattern 0 free-run over a line and a bit
    step(0, 1, 2'd0);
    repeat (1000) step(1, 1, 2'd0);

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
